// File: rtl/reg_file_sb.sv
// Register file with a per-register pending scoreboard for RAW/WAW hazard detection.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to the read ports.
module reg_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            reg_write,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] write_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] out1,
    output logic [XLEN-1:0] out2,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    output logic            busy1,
    output logic            busy2,
    output logic [AW:0]     pending_cnt
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_pending;
    logic [AW:0]      r_cnt;

    logic             w_set;
    logic             w_clr;
    logic             w_inc;
    logic             w_dec;
    logic [NREGS-1:0] w_pending_next;
    logic [AW:0]      w_cnt_next;
    logic [XLEN-1:0]  w_rd1;
    logic [XLEN-1:0]  w_rd2;

    // Address 0 is hardwired: it never takes a write and never becomes pending.
    assign w_set = issue_valid && (issue_rd != '0);
    assign w_clr = reg_write && (rd != '0);

    // Set beats clear when issue and writeback hit the same register.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
            if (gi == 0) begin : g_zero
                assign w_pending_next[gi] = 1'b0;
            end else begin : g_nz
                assign w_pending_next[gi] = (w_set && (issue_rd == AW'(gi))) ||
                                            (r_pending[gi] && !(w_clr && (rd == AW'(gi))));
            end
        end
    endgenerate

    // Counter tracks popcount of the pending vector incrementally.
    assign w_inc = w_set && !r_pending[issue_rd];
    assign w_dec = w_clr && r_pending[rd] && !(w_set && (issue_rd == rd));

    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_inc, w_dec})
            2'b10:   w_cnt_next = r_cnt + 1'b1;
            2'b01:   w_cnt_next = r_cnt - 1'b1;
            default: w_cnt_next = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_clr) begin
                r_regs[rd] <= write_data;
            end
            r_pending <= w_pending_next;
            r_cnt     <= w_cnt_next;
        end
    end

    assign w_rd1 = (rs1 == '0) ? '0 : r_regs[rs1];
    assign w_rd2 = (rs2 == '0) ? '0 : r_regs[rs2];

`ifdef REG_FILE_BYPASS_EN
    // A register being written back this cycle is no longer a hazard for its readers.
    assign out1  = (w_clr && (rs1 == rd)) ? write_data : w_rd1;
    assign out2  = (w_clr && (rs2 == rd)) ? write_data : w_rd2;
    assign busy1 = r_pending[rs1] && !(reg_write && (rd == rs1));
    assign busy2 = r_pending[rs2] && !(reg_write && (rd == rs2));
`else
    assign out1  = w_rd1;
    assign out2  = w_rd2;
    assign busy1 = r_pending[rs1];
    assign busy2 = r_pending[rs2];
`endif

    assign issue_ready = !r_pending[issue_rd];
    assign pending_cnt = r_cnt;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: stimulus queues expected outputs, a negedge monitor checks them.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_write = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] write_data = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [31:0] out1;
    logic [31:0] out2;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        issue_ready;
    logic        busy1;
    logic        busy2;
    logic [5:0]  pending_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // mask bits: 5 out1, 4 out2, 3 busy1, 2 busy2, 1 issue_ready, 0 pending_cnt
    typedef struct {
        int          id;
        logic [5:0]  m;
        logic [31:0] o1;
        logic [31:0] o2;
        logic        b1;
        logic        b2;
        logic        rdy;
        logic [5:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   chk_id = 0;

    reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_write   (reg_write),
        .rd          (rd),
        .write_data  (write_data),
        .rs1         (rs1),
        .rs2         (rs2),
        .out1        (out1),
        .out2        (out2),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .busy1       (busy1),
        .busy2       (busy2),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic we, input logic [4:0] a_rd,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                         input logic iv, input logic [4:0] ird);
        @(posedge clk);
        #1;
        rst         = r;
        reg_write   = we;
        rd          = a_rd;
        write_data  = wd;
        rs1         = a1;
        rs2         = a2;
        issue_valid = iv;
        issue_rd    = ird;
    endtask

    task automatic expect_out(input logic [5:0] m, input logic [31:0] o1, input logic [31:0] o2,
                              input logic b1, input logic b2, input logic rdy, input logic [5:0] cnt);
        exp_t e;
        chk_id++;
        e.id = chk_id; e.m = m; e.o1 = o1; e.o2 = o2;
        e.b1 = b1; e.b2 = b2; e.rdy = rdy; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic cmp(input int id, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL chk%0d %s: got 0x%0h, expected 0x%0h", id, f, act, exp);
        end else begin
            $display("[TB] ok   chk%0d %s = 0x%0h", id, f, act);
        end
    endtask

    // Monitor: combinational outputs are settled by the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.m[5]) cmp(e.id, "out1", out1, e.o1);
            if (e.m[4]) cmp(e.id, "out2", out2, e.o2);
            if (e.m[3]) cmp(e.id, "busy1", 32'(busy1), 32'(e.b1));
            if (e.m[2]) cmp(e.id, "busy2", 32'(busy2), 32'(e.b2));
            if (e.m[1]) cmp(e.id, "issue_ready", 32'(issue_ready), 32'(e.rdy));
            if (e.m[0]) cmp(e.id, "pending_cnt", 32'(pending_cnt), 32'(e.cnt));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset, then read rs1=1 rs2=2
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 2, 0, 0);
        expect_out(6'b111111, 0, 0, 0, 0, 1, 0);

        // write r3=7, then read r3/r4 while writing r0
        drive(0, 1, 3, 32'd7, 1, 2, 0, 0);
        drive(0, 1, 0, 32'hFFFF_FFFF, 3, 4, 0, 0);
        expect_out(6'b110000, 7, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 3, 0, 0);
        expect_out(6'b110001, 0, 7, 0, 0, 0, 0);

        // issue r5, observe hazard, then write back 9
        drive(0, 0, 0, 0, 5, 0, 1, 5);
        expect_out(6'b001011, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 5, 0, 0, 5);
        expect_out(6'b001011, 0, 0, 1, 0, 0, 1);
        drive(0, 1, 5, 32'd9, 5, 0, 0, 5);
`ifdef REG_FILE_BYPASS_EN
        expect_out(6'b101001, 9, 0, 0, 0, 0, 1);
`else
        expect_out(6'b101001, 0, 0, 1, 0, 0, 1);
`endif
        drive(0, 0, 0, 0, 5, 0, 0, 5);
        expect_out(6'b101011, 9, 0, 0, 0, 1, 0);

        // simultaneous issue+write r6: set wins, data still written
        drive(0, 1, 6, 32'd4, 0, 0, 1, 6);
        drive(0, 0, 0, 0, 6, 0, 0, 6);
        expect_out(6'b101011, 4, 0, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 8);
        // issue r7 while writing pending r8: count unchanged
        drive(0, 1, 8, 32'h88, 0, 0, 1, 7);
        expect_out(6'b000001, 0, 0, 0, 0, 0, 2);
        drive(0, 0, 0, 0, 7, 8, 1, 10);
        expect_out(6'b011111, 0, 32'h88, 1, 0, 1, 2);

        // write r10 (pending) while reading it in the same cycle
        drive(0, 1, 10, 32'h55, 10, 0, 0, 0);
`ifdef REG_FILE_BYPASS_EN
        expect_out(6'b101001, 32'h55, 0, 0, 0, 0, 3);
`else
        expect_out(6'b101001, 0, 0, 1, 0, 0, 3);
`endif
        // re-issue already pending r6
        drive(0, 0, 0, 0, 10, 0, 1, 6);
        expect_out(6'b101011, 32'h55, 0, 0, 0, 0, 2);
        // write non-pending r3
        drive(0, 1, 3, 32'h33, 6, 0, 0, 0);
        expect_out(6'b001001, 0, 0, 1, 0, 0, 2);
        drive(0, 0, 0, 0, 3, 3, 0, 0);
        expect_out(6'b111101, 32'h33, 32'h33, 0, 0, 0, 2);

        // issue every register 1..31
        for (int i = 1; i < 32; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 5'(i));
        end
        drive(0, 0, 0, 0, 31, 1, 0, 20);
        expect_out(6'b001111, 0, 0, 1, 1, 0, 31);

        // reset wins over a write and an issue in the same cycle
        drive(1, 1, 2, 32'h22, 0, 0, 1, 4);
        drive(0, 0, 0, 0, 2, 3, 1, 0);
        expect_out(6'b111111, 0, 0, 0, 0, 1, 0);
        // issue to r0 ignored
        drive(0, 0, 0, 0, 0, 4, 0, 4);
        expect_out(6'b101111, 0, 0, 0, 0, 1, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
